// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester RAM port arbiter: state encoding and
// default data/address widths matching the 32x16 RAM.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  typedef enum logic [2:0] {
    StIdle  = S_IDLE,
    StSetup = S_SETUP,
    StWrite = S_WRITE,
    StRead  = S_READ,
    StWait  = S_WAIT,
    StResp  = S_RESP
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the requester that was
// not granted last wins.
module mem_port_arbiter_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic sel,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    sel   = (req0 & req1) ? ~last_gnt : req1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises whole read/write transactions from two requesters onto one
// synchronous-read RAM port; every output is registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int unsigned CNT_W = $clog2(READ_LAT) + 1;

  state_e            state;
  logic              sel_q;
  logic              we_q;
  logic              last_gnt;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              pick_sel;
  logic              pick_valid;

  mem_port_arbiter_rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .sel      (pick_sel),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      last_gnt    <= 1'b1;
      wdata_q     <= '0;
      cnt         <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      mem_address <= '0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
      mem_data    <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
      mem_data <= '0;
      unique case (state)
        StIdle: begin
          if (pick_valid) begin
            sel_q       <= pick_sel;
            last_gnt    <= pick_sel;
            we_q        <= pick_sel ? we1 : we0;
            wdata_q     <= pick_sel ? wdata1 : wdata0;
            mem_address <= pick_sel ? addr1 : addr0;
            gnt0        <= ~pick_sel;
            gnt1        <= pick_sel;
            busy        <= 1'b1;
            state       <= StSetup;
          end
        end
        StSetup: begin
          if (we_q) begin
            mem_wren <= 1'b1;
            mem_data <= wdata_q;
            state    <= StWrite;
          end else begin
            mem_rden <= 1'b1;
            cnt      <= CNT_W'(READ_LAT - 1);
            state    <= StRead;
          end
        end
        StWrite: begin
          done0 <= ~sel_q;
          done1 <= sel_q;
          state <= StResp;
        end
        StRead: state <= StWait;
        StWait: begin
          if (cnt == '0) begin
            rdata <= mem_q;
            done0 <= ~sel_q;
            done1 <= sel_q;
            state <= StResp;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StResp: begin
          mem_address <= '0;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-timeline model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy, mem_rden, mem_wren;
  logic [15:0] rdata, mem_data;
  logic [4:0]  mem_address;
  logic [15:0] mem_q;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic chk_en = 1'b0;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(5), .READ_LAT(RL)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .done0       (done0),
    .done1       (done1),
    .rdata       (rdata),
    .busy        (busy),
    .mem_address (mem_address),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_data    (mem_data),
    .mem_q       (mem_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // RAM: registered write, READ_LAT=2 read pipeline; junk when no read is in flight.
  logic [15:0] ram [32];
  logic [15:0] ram_p1;
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32; i++) ram[i] <= 16'(i * 37);
      ram[3]     <= 16'h1234;
      ram_loaded <= 1'b1;
    end else if (mem_wren) begin
      ram[mem_address] <= mem_data;
    end
    ram_p1 <= mem_rden ? ram[mem_address] : 16'hDEAD;
    mem_q  <= ram_p1;
  end

  // Model: one transaction at a time, tracked by its cycle offset from the sample edge.
  logic        m_active, m_sel, m_we, m_last;
  int          m_t;
  logic [4:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [15:0] mem_m [32];
  logic        m_loaded = 1'b0;
  int          m_end;
  assign m_end = m_we ? 3 : 3 + RL;

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? !last : r1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!m_loaded) begin
      for (int i = 0; i < 32; i++) mem_m[i] <= 16'(i * 37);
      mem_m[3] <= 16'h1234;
      m_loaded <= 1'b1;
    end
    if (!reset) begin
      m_active <= 1'b0;
      m_last   <= 1'b1;
      m_rdata  <= 16'h0;
      m_t      <= 0;
      m_we     <= 1'b0;
    end else if (m_active) begin
      if (m_t == m_end) m_active <= 1'b0;
      else begin
        m_t <= m_t + 1;
        if (m_we && m_t + 1 == 3) mem_m[m_addr] <= m_wdata;
        if (!m_we && m_t + 1 == m_end) m_rdata <= mem_m[m_addr];
      end
    end else if (req0 || req1) begin
      m_sel    <= pick(req0, req1, m_last);
      m_last   <= pick(req0, req1, m_last);
      m_we     <= pick(req0, req1, m_last) ? we1 : we0;
      m_addr   <= pick(req0, req1, m_last) ? addr1 : addr0;
      m_wdata  <= pick(req0, req1, m_last) ? wdata1 : wdata0;
      m_active <= 1'b1;
      m_t      <= 1;
    end
  end

  wire       e_gnt0  = m_active && (m_t == 1) && !m_sel;
  wire       e_gnt1  = m_active && (m_t == 1) && m_sel;
  wire       e_done0 = m_active && (m_t == m_end) && !m_sel;
  wire       e_done1 = m_active && (m_t == m_end) && m_sel;
  wire       e_wren  = m_active && (m_t == 2) && m_we;
  wire       e_rden  = m_active && (m_t == 2) && !m_we;
  wire [4:0] e_addr  = m_active ? m_addr : 5'd0;

  int   gq[$];
  logic [4:0] prev_addr;
  logic prev_wren;

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt0", gnt0, e_gnt0);
      check("gnt1", gnt1, e_gnt1);
      check("done0", done0, e_done0);
      check("done1", done1, e_done1);
      check("busy", busy, m_active);
      check("mem_address", mem_address, e_addr);
      check("mem_wren", mem_wren, e_wren);
      check("mem_rden", mem_rden, e_rden);
      check("rdata", rdata, m_rdata);
      check("rden_wren_excl", mem_rden & mem_wren, 1'b0);
      check("gnt_excl", gnt0 & gnt1, 1'b0);
      check("done_excl", done0 & done1, 1'b0);
      if (e_wren) check("mem_data", mem_data, m_wdata);
      if (mem_wren && !prev_wren) check("addr_setup", mem_address, prev_addr);
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
    end
    prev_addr <= mem_address;
    prev_wren <= mem_wren;
  end

  task automatic do_txn(input logic port, input logic we, input logic [4:0] addr,
                        input logic [15:0] wd, output int kg, output int kc,
                        output int kd, output logic [15:0] rd);
    int cs;
    @(negedge clk);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    cs = cyc; kg = -1; kc = -1; kd = -1; rd = 16'h0;
    for (int i = 0; i < 40 && kd < 0; i++) begin
      @(negedge clk);
      if (port ? gnt1 : gnt0) begin
        kg = cyc - cs;
        if (port) req1 = 1'b0; else req0 = 1'b0;
      end
      if ((mem_wren || mem_rden) && kc < 0) kc = cyc - cs;
      if (port ? done1 : done0) begin kd = cyc - cs; rd = rdata; end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kg, kc, kd, cs, n0, n1, nd;
    logic [15:0] rd;
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // Asynchronous reset mid-cycle.
    #3 reset = 1'b0;
    #1;
    check("rst_gnt", {gnt0, gnt1, done0, done1}, 4'h0);
    check("rst_ctrl", {busy, mem_rden, mem_wren}, 3'h0);
    check("rst_addr", mem_address, 5'd0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_mdata", mem_data, 16'h0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_addr", mem_address, 5'd0);
      check("idle_busy", busy, 1'b0);
    end

    // Single write from requester 1.
    do_txn(1'b1, 1'b1, 5'd7, 16'h00A5, kg, kc, kd, rd);
    check("wr_gnt_lat", kg, 1);
    check("wr_wren_lat", kc, 2);
    check("wr_done_lat", kd, 3);
    repeat (2) @(negedge clk);

    // Contention: both held, each dropped on its gnt and re-raised a cycle later.
    gq.delete();
    we0 = 1'b0; addr0 = 5'd3; we1 = 1'b1; addr1 = 5'd10; wdata1 = 16'h5A5A;
    req0 = 1'b1; req1 = 1'b1; n0 = 0; n1 = 0;
    for (int i = 0; i < 300 && (n0 < 3 || n1 < 3); i++) begin
      @(negedge clk);
      if (gnt0) begin n0++; req0 = 1'b0; end else req0 = (n0 < 3);
      if (gnt1) begin n1++; req1 = 1'b0; end else req1 = (n1 < 3);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("grant_count", gq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) check("grant_order", gq[i], i % 2);
    repeat (2) @(negedge clk);

    // Single read from requester 0.
    do_txn(1'b0, 1'b0, 5'd3, 16'h0, kg, kc, kd, rd);
    check("rd_gnt_lat", kg, 1);
    check("rd_rden_lat", kc, 2);
    check("rd_done_lat", kd, 5);
    check("rd_data", rd, 16'h1234);

    // Read-after-write at the top address.
    do_txn(1'b1, 1'b1, 5'd31, 16'hBEEF, kg, kc, kd, rd);
    check("raw_wr_done", kd, 3);
    do_txn(1'b0, 1'b0, 5'd31, 16'h0, kg, kc, kd, rd);
    check("raw_rd_done", kd, 5);
    check("raw_rd_data", rd, 16'hBEEF);

    // Reset during WAIT abandons the read.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3; cs = cyc;
    for (int i = 0; i < 20 && (cyc - cs) < 3; i++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
    end
    req0 = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_rden", mem_rden, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done0", done0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done0) nd++;
    end
    check("midrst_no_done", nd, 0);
    do_txn(1'b0, 1'b0, 5'd3, 16'h0, kg, kc, kd, rd);
    check("post_rst_done", kd, 5);
    check("post_rst_data", rd, 16'h1234);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 32x16 RAM (synchronous read, rden/wren) between two requesters.
- Requester 0 is the accumulator controller; requester 1 is a host/loader port.
- Serialises whole transactions, one at a time, with fair round-robin grant.
- Enforces the RAM timing rules: address stable ≥1 cycle before wren rises and throughout wren, rden pulse, fixed read latency.

Parameters:
- DATA_W, 16, RAM word width
- ADDR_W, 5, RAM address width
- READ_LAT, 2, cycles from the rden cycle until mem_q is valid (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  transaction request; held high until the matching gnt
- we0 / we1  in  1  1 = write, 0 = read; sampled with req
- addr0 / addr1  in  ADDR_W  transaction address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request latched
- done0 / done1  out  1  one-cycle pulse: transaction complete
- rdata  out  DATA_W  read result; valid while done0/done1 is high for a read
- busy  out  1  high in any state except IDLE
- mem_address  out  ADDR_W  to RAM address
- mem_rden  out  1  to RAM rden
- mem_wren  out  1  to RAM wren
- mem_data  out  DATA_W  to RAM data
- mem_q  in  DATA_W  from RAM q

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - All outputs 0: gnt*, done*, rdata, busy, mem_address, mem_rden, mem_wren, mem_data.
  - last_gnt=1, so req0 wins the first tie.
  - Reset mid-transaction abandons it: no done pulse, wren/rden drop immediately.
- All outputs are registered. No combinational path from req* to any output.
- FSM states: IDLE, SETUP, WRITE, READ, WAIT, RESP.
- IDLE: mem_address=0, controls 0.
  - If only req0 or only req1 is high, select that requester.
  - If both are high, select the one ≠ last_gnt.
  - Latch addr/we/wdata, update last_gnt, go to SETUP.
  - No request: stay in IDLE.
- SETUP, 1 cycle:
  - gnt of the selected requester = 1; mem_address = latched addr; rden=wren=0.
  - Next state: WRITE if we, else READ.
- WRITE, 1 cycle: mem_wren=1, mem_data=latched wdata, address unchanged. Next: RESP.
- READ, 1 cycle: mem_rden=1; load cnt=READ_LAT-1. Next: WAIT.
- WAIT: rden=0, address held, cnt decrements.
  - At cnt==0, capture mem_q into rdata.
  - Next: RESP. WAIT lasts exactly READ_LAT cycles.
- RESP, 1 cycle:
  - done of the selected requester = 1; address still held; controls 0.
  - rdata keeps its value until the next read capture (writes do not alter it).
  - Next: IDLE.
- Latency from the edge that samples req in IDLE:
  - Write: gnt in cycle +1, wren in +2, done in +3.
  - Read: gnt +1, rden +2, done +3+READ_LAT.
  - IDLE lasts ≥1 cycle between transactions, so address returns to 0 for one cycle.
- Boundaries:
  - A request withdrawn before its gnt is simply not served.
  - A request still high after gnt starts a new transaction: the requester must drop req in the gnt cycle.
  - A request arriving during busy waits; under continuous contention, service alternates strictly.
  - addr=31 and addr=0 need no special handling.
  - Only one of mem_rden/mem_wren is ever high; never both.
- Arithmetic: cnt is clog2(READ_LAT)+1 bits, unsigned, no wrap beyond 0.

Decomposition:
- Shared package:
  - State encoding (3-bit localparams S_IDLE..S_RESP).
  - DATA_W/ADDR_W defaults, matching the RAM and the accumulator top.
- Sub-module rr_pick2:
  - Combinational 2-way round-robin selector (req0, req1, last_gnt → sel, valid).
  - Keeps the FSM free of priority logic.

Test Plan:
- Reset then idle: reset=0 mid-cycle → all outputs 0 immediately; after release with no req, mem_address stays 0 and busy=0 for 10 cycles.
- Single write: req1=1, we1=1, addr1=7, wdata1=16'h00A5:
  - gnt1 at +1; mem_address=7 from +1 through +3.
  - mem_wren=1 only at +2, with mem_data=16'h00A5; done1 at +3.
  - Bench checks address changes ≥1 cycle before wren rises.
- Single read, READ_LAT=2: RAM preloaded [3]=16'h1234; req0=1, we0=0, addr0=3 → rden only at +2, done0 at +5 with rdata=16'h1234.
- Contention: req0 and req1 both held high, each dropped on its own gnt and re-raised one cycle later, for 6 transactions → grant order 0,1,0,1,0,1. Never both gnt or both done at once.
- Read-after-write: write 16'hBEEF to addr 31 via req1, then read addr 31 via req0 → rdata=16'hBEEF at done0.
- Reset mid-read: assert reset during WAIT → mem_rden=0, no done0 ever pulses, next req0 after release is served normally.
